midr_fetch: RTL
===============

MIDR_FETCH -- requirements
Module: midr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15, SHALL be the number of un-acked request cycles tolerated before a fetch error.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 start  input  1  SHALL, when high in IDLE, begin fetching at the current PC.
REQ-006 mem_req  output  1  SHALL be the instruction-memory read request.
REQ-007 mem_addr  output  16  SHALL be the word address of the request, equal to pc_out.
REQ-008 mem_ack  input  1  SHALL indicate that mem_rdata holds valid data this cycle.
REQ-009 mem_rdata  input  16  SHALL be the instruction word returned by memory.
REQ-010 MIDR_out  output  16  SHALL be the latched instruction, consumed by the RG1/RG2 field extractors.
REQ-011 instr_valid  output  1  SHALL indicate that MIDR_out holds an instruction not yet accepted by decode.
REQ-012 instr_ready  input  1  SHALL indicate that decode accepts MIDR_out this cycle.
REQ-013 pc_load  input  1  SHALL request a PC redirect (jump/branch).
REQ-014 pc_load_val  input  16  SHALL be the redirect target.
REQ-015 pc_out  output  16  SHALL be the current fetch PC.
REQ-016 fetch_err  output  1  SHALL indicate a memory timeout (sticky).

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, VALID, ERR.
REQ-018 IDLE: mem_req=0 and instr_valid=0; start=1 -> REQ on the next cycle.
REQ-019 REQ: mem_req=1 and mem_addr=pc_out.
- mem_ack=1 -> MIDR_out<=mem_rdata, pc<=pc+1, wait counter cleared, next state VALID.
- otherwise wait counter +1.
REQ-020 In REQ, a wait counter reaching MAX_WAIT without ack SHALL move the FSM to ERR; at MAX_WAIT=15, mem_req stays high for exactly 15 cycles.
REQ-021 VALID: instr_valid=1 and MIDR_out held stable; instr_ready=1 -> REQ on the next cycle (back-to-back fetch); otherwise hold.
REQ-022 Fetch latency SHALL be 1 cycle from the mem_ack edge to instr_valid=1.
REQ-023 ERR: fetch_err=1, mem_req=0, instr_valid=0; exit only via rst.
REQ-024 pc_load=1 in IDLE SHALL set pc<=pc_load_val and keep the FSM in IDLE.
REQ-025 pc_load=1 in REQ SHALL set pc<=pc_load_val, discard any same-cycle mem_ack data (MIDR_out unchanged), clear the wait counter and stay in REQ, issuing the new address next cycle.
REQ-026 pc_load=1 in VALID SHALL flush the instruction, set pc<=pc_load_val and go to REQ; if instr_ready is high in the same cycle, the handshake completes and the redirect also applies.
REQ-027 pc_load SHALL be ignored in ERR.
REQ-028 PC increment SHALL be modulo 2^16: 16'hFFFF+1 -> 16'h0000, with no flag.
REQ-029 mem_ack outside REQ SHALL be ignored.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set:
- state=IDLE, pc_out=RESET_PC, MIDR_out=16'h0000;
- instr_valid=0, mem_req=0, fetch_err=0, wait counter=0.
REQ-031 Reset SHALL override all other inputs, including mid-request, and outstanding memory data SHALL be discarded.

Structure
REQ-032 A shared package SHALL hold the fetch-state enum, the 16-bit word/address width constants and the RESET_PC default.
REQ-033 The PC register with increment/load/wrap logic SHALL be a sub-module named midr_pc.

Verification
REQ-034 Bench scenarios SHALL cover:
- Reset, start, ack in the first REQ cycle with rdata=16'h1234 -> instr_valid next cycle, MIDR_out=16'h1234, pc_out=1.
- instr_ready held low for 5 cycles -> MIDR_out and instr_valid stable; ready=1 -> REQ with mem_addr=1.
- pc_load_val=16'h0040 in the same REQ cycle as ack with rdata=16'hBEEF -> MIDR_out unchanged, next mem_addr=16'h0040.
- pc=16'hFFFF, fetch acked -> pc_out=16'h0000.
- No ack for 15 REQ cycles -> fetch_err=1, mem_req=0; rst -> IDLE, fetch_err=0.
- rst asserted while in VALID -> next cycle instr_valid=0, MIDR_out=16'h0000, pc_out=RESET_PC.

Source files
------------

// File: rtl/midr_fetch_pkg.sv
// Shared fetch-stage types and constants for the MIDR instruction fetch unit.
// Holds the FSM state encoding and the word/address widths.
package midr_fetch_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_VALID,
        ST_ERR
    } fetch_state_t;

endpackage

// File: rtl/midr_pc.sv
// Fetch program counter: a redirect load beats an increment.
// The increment wraps modulo 2^ADDR_W.
module midr_pc
    import midr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/midr_fetch.sv
// MIDR fetch unit: requests a word at the PC, latches it into MIDR and
// holds it for decode. A request that is not acknowledged in time raises a sticky error.
module midr_fetch
    import midr_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] MIDR_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    fetch_state_t  state;
    logic [CW-1:0] wait_cnt;
    logic          pc_ld;
    logic          pc_inc;

    // A redirect in REQ takes priority, so ack data arriving with it is dropped.
    assign pc_ld  = pc_load && (state != ST_ERR);
    assign pc_inc = (state == ST_REQ) && mem_ack && !pc_load;

    midr_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_ld),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc_out)
    );

    assign mem_addr = pc_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            MIDR_out    <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!pc_load && start) begin
                        state   <= ST_REQ;
                        mem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (pc_load) begin
                        wait_cnt <= '0;
                    end else if (mem_ack) begin
                        MIDR_out    <= mem_rdata;
                        wait_cnt    <= '0;
                        state       <= ST_VALID;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                    end else if (wait_cnt == LAST_WAIT) begin
                        wait_cnt  <= wait_cnt + CW'(1);
                        state     <= ST_ERR;
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_VALID: begin
                    if (pc_load || instr_ready) begin
                        state       <= ST_REQ;
                        mem_req     <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                ST_ERR: begin
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
            endcase
        end
    end

endmodule
